// File: rtl/tx_lane_switch_sequencer.sv
// Lane-switch sequencer: drains the monitored AXI-Stream to a packet boundary, pulses lane-on,
// waits for lane-done (with timeout), settles, then re-arms the gate. Option: TX_SWITCH_RST_COUNT_EN.
module tx_lane_switch_sequencer #(
    parameter int TIMESTAMP_WIDTH = 64,
    parameter int LAT_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       req_valid,
    input  logic                       req_lane,
    output logic                       req_ready,
    input  logic                       mon_tvalid,
    input  logic                       mon_tready,
    input  logic                       mon_tlast,
    output logic                       hold,
    output logic                       switch_lane0_on,
    output logic                       switch_lane1_on,
    input  logic                       switch_lane0_done,
    input  logic                       switch_lane1_done,
    output logic                       gate_ctrl,
    output logic                       rst_count,
    input  logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
    output logic                       lat_valid,
    output logic                       lat_lane,
    output logic [LAT_WIDTH-1:0]       lat_cycles,
    output logic                       err_timeout,
    output logic                       busy
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DRAIN     = 3'd1,
        S_SWITCH    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_SETTLE    = 3'd4,
        S_RESUME    = 3'd5
    } state_e;

    state_e                     state_q, state_d;
    logic                       lane_q, lane_d;
    logic                       in_pkt_q, in_pkt_d;
    logic [WCNT_W-1:0]          wcnt_q, wcnt_d;
    logic [SCNT_W-1:0]          scnt_q, scnt_d;
    logic [TIMESTAMP_WIDTH-1:0] t_on_q, t_on_d;
    logic                       timeout_q, timeout_d;
    logic                       lat_valid_q, lat_valid_d;
    logic                       lat_lane_q, lat_lane_d;
    logic [LAT_WIDTH-1:0]       lat_cycles_q, lat_cycles_d;
    logic                       req_ready_q, req_ready_d;
    logic                       rst_count_d;
    logic                       beat_s;
    logic                       done_s;

    assign beat_s = mon_tvalid & mon_tready;
    assign done_s = lane_q ? switch_lane1_done : switch_lane0_done;

    // Next-state, packet tracking and latency capture
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        wcnt_d       = wcnt_q;
        scnt_d       = scnt_q;
        t_on_d       = t_on_q;
        timeout_d    = timeout_q;
        lat_valid_d  = 1'b0;
        lat_lane_d   = lat_lane_q;
        lat_cycles_d = lat_cycles_q;
        rst_count_d  = 1'b0;

        if (beat_s) begin
            in_pkt_d = ~mon_tlast;
        end else begin
            in_pkt_d = in_pkt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d     = S_DRAIN;
                    lane_d      = req_lane;
                    timeout_d   = 1'b0;
                    rst_count_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            // A last beat accepted this cycle closes the packet, so the switch may follow immediately.
            S_DRAIN: begin
                if (!in_pkt_d) begin
                    state_d = S_SWITCH;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_SWITCH: begin
                t_on_d  = stamp_counter;
                wcnt_d  = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_s) begin
                    lat_valid_d  = 1'b1;
                    lat_lane_d   = lane_q;
                    lat_cycles_d = LAT_WIDTH'(stamp_counter - t_on_q);
                    scnt_d       = '0;
                    state_d      = S_SETTLE;
                end else if (wcnt_q == WCNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_RESUME;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (scnt_q == SCNT_LAST) begin
                    state_d = S_RESUME;
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end
            S_RESUME: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    // Sequencer state registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            lane_q       <= 1'b0;
            in_pkt_q     <= 1'b0;
            wcnt_q       <= '0;
            scnt_q       <= '0;
            t_on_q       <= '0;
            timeout_q    <= 1'b0;
            lat_valid_q  <= 1'b0;
            lat_lane_q   <= 1'b0;
            lat_cycles_q <= '0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            in_pkt_q     <= in_pkt_d;
            wcnt_q       <= wcnt_d;
            scnt_q       <= scnt_d;
            t_on_q       <= t_on_d;
            timeout_q    <= timeout_d;
            lat_valid_q  <= lat_valid_d;
            lat_lane_q   <= lat_lane_d;
            lat_cycles_q <= lat_cycles_d;
            req_ready_q  <= req_ready_d;
        end
    end

`ifdef TX_SWITCH_RST_COUNT_EN
    logic rst_count_q;

    // One pulse on the first DRAIN cycle of each sequence
    always_ff @(posedge aclk) begin
        if (areset) begin
            rst_count_q <= 1'b0;
        end else begin
            rst_count_q <= rst_count_d;
        end
    end

    assign rst_count = rst_count_q;
`else
    logic unused_rst_count_s;
    assign unused_rst_count_s = rst_count_d;
    assign rst_count          = 1'b0;
`endif

    assign req_ready       = req_ready_q;
    assign busy            = (state_q != S_IDLE);
    assign hold            = (state_q == S_DRAIN) || (state_q == S_SWITCH) ||
                             (state_q == S_WAIT_DONE) || (state_q == S_SETTLE);
    assign switch_lane0_on = (state_q == S_SWITCH) && !lane_q;
    assign switch_lane1_on = (state_q == S_SWITCH) && lane_q;
    assign gate_ctrl       = (state_q == S_RESUME);
    assign err_timeout     = (state_q == S_RESUME) && timeout_q;
    assign lat_valid       = lat_valid_q;
    assign lat_lane        = lat_lane_q;
    assign lat_cycles      = lat_cycles_q;

endmodule

// File: tb/tb_tx_lane_switch_sequencer.sv
// Scoreboard bench for tx_lane_switch_sequencer: transactions push expected pulses into a queue,
// a negedge monitor pops and compares every pulse the DUT produces.
module tb_tx_lane_switch_sequencer;

    localparam int T = 12;
    localparam int S = 4;

    logic        aclk = 1'b0;
    logic        areset;
    logic        req_valid, req_lane, req_ready;
    logic        mon_tvalid, mon_tready, mon_tlast;
    logic        hold, switch_lane0_on, switch_lane1_on;
    logic        switch_lane0_done, switch_lane1_done;
    logic        gate_ctrl, rst_count;
    logic [63:0] stamp_counter;
    logic        lat_valid, lat_lane;
    logic [31:0] lat_cycles;
    logic        err_timeout, busy;

    tx_lane_switch_sequencer #(
        .TIMESTAMP_WIDTH(64), .LAT_WIDTH(32), .TIMEOUT_CYCLES(T), .SETTLE_CYCLES(S)
    ) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_lane(req_lane), .req_ready(req_ready),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
        .hold(hold), .switch_lane0_on(switch_lane0_on), .switch_lane1_on(switch_lane1_on),
        .switch_lane0_done(switch_lane0_done), .switch_lane1_done(switch_lane1_done),
        .gate_ctrl(gate_ctrl), .rst_count(rst_count), .stamp_counter(stamp_counter),
        .lat_valid(lat_valid), .lat_lane(lat_lane), .lat_cycles(lat_cycles),
        .err_timeout(err_timeout), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        int              kind;   // 0 rst_count, 1 lane_on, 2 latency, 3 gate
        int              lane;
        longint unsigned data;
    } ev_t;
    ev_t exp_q[$];

    int n_pass = 0;
    int n_total = 0;
    int last_lat = 0;
    int last_lane = 0;

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    endtask

    task automatic push(input int c, input int kind, input int lane, input longint unsigned data);
        ev_t e;
        e.cyc = c; e.kind = kind; e.lane = lane; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic sb_event(input int kind, input int lane, input longint unsigned data);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_pulse cyc=%0d got kind=%0d lane=%0d data=%0d exp none",
                     cyc, kind, lane, data);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc == cyc && e.kind == kind && e.lane == lane && e.data == data) n_pass++;
            else $display("FAIL pulse got cyc=%0d kind=%0d lane=%0d data=%0d exp cyc=%0d kind=%0d lane=%0d data=%0d",
                          cyc, kind, lane, data, e.cyc, e.kind, e.lane, e.data);
        end
    endtask

    // Monitor: every pulse the DUT presents is matched against the scoreboard
    always @(negedge aclk) begin
        if (rst_count) sb_event(0, 0, 0);
        if (switch_lane0_on || switch_lane1_on)
            sb_event(1, (switch_lane0_on && switch_lane1_on) ? 2 : int'(switch_lane1_on), 0);
        if (lat_valid) sb_event(2, int'(lat_lane), longint'(lat_cycles));
        if (gate_ctrl || err_timeout) sb_event(3, int'(err_timeout), longint'(gate_ctrl));
    end

    task automatic next_cycle();
        @(posedge aclk);
        #1;
        stamp_counter = stamp_counter + 64'd1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_lane = 1'b0;
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        switch_lane0_done = 1'b0; switch_lane1_done = 1'b0;
    endtask

    // One full switch sequence; k<0 means no packet, otherwise a packet of n beats starts k cycles before the request
    task automatic run_txn(input bit lane, input int k, input int n, input bit tmo, input int j, input bit wrap);
        int b, r, s, L, d, res, idle;
        bit has_pkt, beat, in_wait, tgt, oth;
        b = cyc;
        has_pkt = (k >= 0);
        r = has_pkt ? b + k : b;
        L = b + n - 1;
        s = r + 2;
        if (has_pkt && L + 1 > s) s = L + 1;
        d = s + 1 + j;
        res = tmo ? s + T + 1 : d + 1 + S;
        idle = res + 1;
`ifdef TX_SWITCH_RST_COUNT_EN
        push(r + 1, 0, 0, 0);
`endif
        push(s, 1, int'(lane), 0);
        if (!tmo) begin
            push(d + 1, 2, int'(lane), longint'(d - s));
            last_lat = d - s;
            last_lane = int'(lane);
        end
        push(res, 3, int'(tmo), 1);
        for (int c = b; c <= idle; c++) begin
            if (c == r) begin
                req_valid = 1'b1; req_lane = lane;
            end else if (c > r && c <= res) begin
                req_valid = ($urandom_range(0, 3) == 0);
                req_lane = 1'($urandom_range(0, 1));
            end else begin
                req_valid = 1'b0; req_lane = lane;
            end
            if (c == r && wrap) stamp_counter = 64'hFFFF_FFFF_FFFF_FFFD - 64'(s - r);
            beat = has_pkt && c >= b && c <= L;
            if (beat) begin
                mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = (c == L);
            end else begin
                mon_tvalid = 1'($urandom_range(0, 1));
                mon_tready = mon_tvalid ? 1'b0 : 1'($urandom_range(0, 1));
                mon_tlast = 1'($urandom_range(0, 1));
            end
            in_wait = (c >= s + 1) && (c <= (tmo ? s + T : d));
            tgt = (!tmo && c == d) || (!in_wait && $urandom_range(0, 3) == 0);
            oth = ($urandom_range(0, 2) == 0);
            switch_lane0_done = lane ? oth : tgt;
            switch_lane1_done = lane ? tgt : oth;
            @(negedge aclk);
            chk("busy", busy, (c > r && c <= res));
            chk("hold", hold, (c > r && c < res));
            chk("req_ready", req_ready, (c <= r || c > res));
            if (c == idle) begin
                chk("lat_cycles_hold", lat_cycles, longint'(last_lat));
                chk("lat_lane_hold", lat_lane, longint'(last_lane));
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    // Sequence aborted by reset in WAIT_DONE; late done pulses must have no effect
    task automatic run_abort(input bit lane);
        int b, r, s, a;
        b = cyc; r = b; s = r + 2;
        a = s + 1 + int'($urandom_range(0, T - 2));
`ifdef TX_SWITCH_RST_COUNT_EN
        push(r + 1, 0, 0, 0);
`endif
        push(s, 1, int'(lane), 0);
        for (int c = b; c <= a + 4; c++) begin
            req_valid = (c == r); req_lane = lane;
            areset = (c == a);
            switch_lane0_done = !lane && (c == a + 1 || c == a + 2);
            switch_lane1_done = lane && (c == a + 1 || c == a + 2);
            @(negedge aclk);
            if (c > r && c <= a) chk("abort_busy", busy, 1);
            if (c == a + 1) begin
                chk("abort_busy0", busy, 0);
                chk("abort_hold0", hold, 0);
                chk("abort_ready_in_reset", req_ready, 0);
                chk("abort_lat_cleared", lat_cycles, 0);
            end
            if (c >= a + 2) begin
                chk("abort_ready", req_ready, 1);
                chk("abort_idle", busy, 0);
            end
            next_cycle();
        end
        last_lat = 0; last_lane = 0;
        idle_inputs();
    endtask

    initial begin
        areset = 1'b1;
        stamp_counter = 64'd0;
        idle_inputs();
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            chk("rst_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_hold", hold, 0);
            chk("rst_lat_cycles", lat_cycles, 0);
            next_cycle();
        end
        areset = 1'b0;
        @(negedge aclk);
        chk("rel_ready_first", req_ready, 0);
        next_cycle();
        @(negedge aclk);
        chk("rel_ready", req_ready, 1);
        next_cycle();

        run_txn(1'b0, -1, 1, 1'b0, 7, 1'b0);   // done 8 cycles after lane-on
        run_txn(1'b1, 0, 5, 1'b0, 3, 1'b0);    // packet in flight delays the switch
        run_txn(1'b1, -1, 1, 1'b1, 0, 1'b0);   // only the wrong lane's done: timeout
        run_txn(1'b0, -1, 1, 1'b0, 4, 1'b1);   // stamp wraps between on and done
        run_txn(1'b1, 1, 2, 1'b0, T - 1, 1'b0); // done in last WAIT_DONE cycle wins
        run_abort(1'b0);
        for (int i = 0; i < 24; i++) begin
            int k;
            k = int'($urandom_range(0, 3));
            run_txn(1'($urandom_range(0, 1)), (k == 3) ? -1 : k, int'($urandom_range(1, 5)),
                    ($urandom_range(0, 4) == 0), int'($urandom_range(0, T - 1)),
                    ($urandom_range(0, 3) == 0));
            if (i == 12) run_abort(1'b1);
        end
        for (int i = 0; i < 3; i++) next_cycle();
        @(negedge aclk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
